// File: rtl/snake_input_ctrl.sv
// Snake game button front end: per-button synchroniser and debouncer, pause toggle,
// restart pulse and a bounded direction-change queue. Optional: SNAKE_INPUT_REVERSAL_FILTER_EN.
module snake_input_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int QUEUE_DEPTH     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_up,
  input  logic                             i_down,
  input  logic                             i_left,
  input  logic                             i_right,
  input  logic                             i_pause,
  input  logic                             i_restart,
  input  logic                             i_tick,
  output logic [1:0]                       o_dir,
  output logic                             o_paused,
  output logic                             o_restart,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] o_level,
  output logic                             o_drop
);

  localparam int NB = 6;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int LW = $clog2(QUEUE_DEPTH + 1);
  localparam int BTN_PAUSE   = 4;
  localparam int BTN_RESTART = 5;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  logic [NB-1:0] w_raw;
  logic [NB-1:0] r_sync [SYNC_STAGES];
  logic [NB-1:0] w_synced;
  logic [NB-1:0] r_deb;
  logic [NB-1:0] r_deb_prev;
  logic [CW-1:0] r_cnt [NB];
  logic [NB-1:0] w_press;

  assign w_raw    = {i_restart, i_pause, i_right, i_left, i_down, i_up};
  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_press  = r_deb & ~r_deb_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= w_raw;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  // Debounced state flips after DEBOUNCE_CYCLES consecutive disagreeing synchronised samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb      <= '0;
      r_deb_prev <= '0;
      for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
    end else begin
      r_deb_prev <= r_deb;
      for (int i = 0; i < NB; i++) begin
        if (w_synced[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_deb[i] <= ~r_deb[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic       w_dir_vld;
  logic [1:0] w_dir_sel;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_dir_vld = |w_press[3:0];
    w_dir_sel = DIR_RIGHT;
    if      (w_press[0]) w_dir_sel = 2'd0;
    else if (w_press[1]) w_dir_sel = 2'd1;
    else if (w_press[2]) w_dir_sel = 2'd2;
  end

  logic [1:0]    r_q [QUEUE_DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [PW-1:0] w_wr_last;
  logic [LW-1:0] r_level;
  logic [1:0]    r_dir;
  logic          r_paused;
  logic          r_restart;
  logic          r_drop;
  logic [1:0]    w_ref;
  logic          w_pop;
  logic          w_full;
  logic          w_rev;
  logic          w_accept;
  logic          w_restart;
  logic          w_push;
  logic          w_drop;

  assign w_wr_last = r_wr - 1'b1;
  assign w_ref     = (r_level != '0) ? r_q[w_wr_last] : r_dir;
  assign w_pop     = i_tick & ~r_paused & (r_level != '0);
  assign w_full    = (r_level == LW'(QUEUE_DEPTH));

`ifdef SNAKE_INPUT_REVERSAL_FILTER_EN
  assign w_rev = (w_dir_sel == (w_ref ^ 2'd1));
`else
  assign w_rev = 1'b0;
`endif

  assign w_restart = w_press[BTN_RESTART];
  assign w_accept  = w_dir_vld & ~r_paused & (w_dir_sel != w_ref) & ~w_rev;
  assign w_push    = w_accept & (~w_full | w_pop) & ~w_restart;
  assign w_drop    = w_accept & w_full & ~w_pop & ~w_restart;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_level   <= '0;
      r_dir     <= DIR_RIGHT;
      r_paused  <= 1'b0;
      r_restart <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_restart <= w_restart;
      r_drop    <= w_drop;
      if (w_restart) begin
        r_wr     <= '0;
        r_rd     <= '0;
        r_level  <= '0;
        r_dir    <= DIR_RIGHT;
        r_paused <= 1'b0;
      end else begin
        if (w_pop) begin
          r_dir <= r_q[r_rd];
          r_rd  <= r_rd + 1'b1;
        end
        if (w_push) r_wr <= r_wr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + 1'b1;
          2'b01:   r_level <= r_level - 1'b1;
          default: r_level <= r_level;
        endcase
        if (w_press[BTN_PAUSE]) r_paused <= ~r_paused;
      end
    end
  end

  // NOTE: queue storage has no reset; r_level and the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wr] <= w_dir_sel;
  end

  assign o_dir     = r_dir;
  assign o_paused  = r_paused;
  assign o_restart = r_restart;
  assign o_level   = r_level;
  assign o_drop    = r_drop;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Self-checking bench for snake_input_ctrl: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_snake_input_ctrl;

  localparam int SYNC  = 2;
  localparam int DEB   = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);
`ifdef SNAKE_INPUT_REVERSAL_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [5:0]    raw;
  logic          i_tick;
  logic [1:0]    o_dir;
  logic          o_paused;
  logic          o_restart;
  logic [LW-1:0] o_level;
  logic          o_drop;

  snake_input_ctrl #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .QUEUE_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .i_up(raw[0]), .i_down(raw[1]), .i_left(raw[2]), .i_right(raw[3]),
    .i_pause(raw[4]), .i_restart(raw[5]), .i_tick(i_tick),
    .o_dir(o_dir), .o_paused(o_paused), .o_restart(o_restart),
    .o_level(o_level), .o_drop(o_drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int drop_cnt = 0;
  int rst_cnt  = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: raw sample history gives the synchronised view; a button's debounced
  // level flips once the last DEB synchronised samples all disagree with it.
  bit rh [6][$];
  bit sh [6][$];
  bit m_deb [6];
  bit m_deb_prev [6];
  int mq [$];
  int m_dir = 3;
  bit m_paused, m_restart, m_drop, m_valid;

  task automatic model_step();
    bit press [6];
    bit sync_out, all_diff, pop, push;
    int d, ref_dir;
    if (rst) begin
      for (int b = 0; b < 6; b++) begin
        rh[b].delete(); sh[b].delete(); m_deb[b] = 0; m_deb_prev[b] = 0;
      end
      mq.delete(); m_dir = 3; m_paused = 0; m_restart = 0; m_drop = 0; m_valid = 1;
      return;
    end
    for (int b = 0; b < 6; b++) press[b] = m_deb[b] && !m_deb_prev[b];
    for (int b = 0; b < 6; b++) begin
      sync_out = (rh[b].size() >= SYNC) ? rh[b][rh[b].size() - SYNC] : 1'b0;
      rh[b].push_back(raw[b]);
      if (rh[b].size() > 64) void'(rh[b].pop_front());
      sh[b].push_back(sync_out);
      if (sh[b].size() > 64) void'(sh[b].pop_front());
      all_diff = (sh[b].size() >= DEB);
      for (int k = 1; k <= DEB && all_diff; k++)
        if (sh[b][sh[b].size() - k] == m_deb[b]) all_diff = 0;
      m_deb_prev[b] = m_deb[b];
      if (all_diff) m_deb[b] = !m_deb[b];
    end
    m_drop = 0; m_restart = 0;
    if (press[5]) begin
      mq.delete(); m_dir = 3; m_paused = 0; m_restart = 1;
    end else begin
      d = -1;
      for (int k = 3; k >= 0; k--) if (press[k]) d = k;
      ref_dir = (mq.size() > 0) ? mq[$] : m_dir;
      pop  = i_tick && !m_paused && (mq.size() > 0);
      push = 0;
      if (d >= 0 && !m_paused && d != ref_dir && !(FILTER && d == (ref_dir ^ 1))) begin
        if (mq.size() == DEPTH && !pop) m_drop = 1;
        else push = 1;
      end
      if (pop) m_dir = mq.pop_front();
      if (push) mq.push_back(d);
      if (press[4]) m_paused = !m_paused;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // One compare per cycle, sampled mid-period.
  initial forever begin
    @(negedge clk);
    if (o_drop) drop_cnt++;
    if (o_restart) rst_cnt++;
    if (m_valid)
      check("cycle_outputs",
            (int'(o_dir) << 8) | (int'(o_paused) << 7) | (int'(o_restart) << 6) |
            (int'(o_drop) << 5) | int'(o_level),
            (m_dir << 8) | (int'(m_paused) << 7) | (int'(m_restart) << 6) |
            (int'(m_drop) << 5) | mq.size());
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    wait_n(2);
    rst = 1'b0;
  endtask

  task automatic press(input int b);
    raw[b] = 1'b1;
    wait_n(25);
    raw[b] = 1'b0;
    wait_n(25);
  endtask

  task automatic tick();
    i_tick = 1'b1;
    wait_n(1);
    i_tick = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_dir"}, int'(o_dir), 3);
    check({name, "_paused"}, int'(o_paused), 0);
    check({name, "_restart"}, int'(o_restart), 0);
    check({name, "_level"}, int'(o_level), 0);
    check({name, "_drop"}, int'(o_drop), 0);
  endtask

  int exp_seq [4];

  initial begin
    rst = 1'b1; raw = '0; i_tick = 1'b0;
    wait_n(1);
    reset_dut();
    check_reset_values("reset");

    // Hold up: first push lands exactly on edge SYNC+DEB+1.
    raw[0] = 1'b1;
    wait_n(18);
    check("up_latency_before", int'(o_level), 0);
    wait_n(1);
    check("up_latency_at", int'(o_level), 1);
    wait_n(21);
    raw[0] = 1'b0;
    wait_n(25);
    tick();
    check("up_tick_dir", int'(o_dir), 0);
    check("up_tick_level", int'(o_level), 0);

    // Five presses without ticks.
    reset_dut();
    press(2); press(1); press(3); press(0);
    drop_cnt = 0;
    press(2);
    check("fill_drop_count", drop_cnt, FILTER ? 0 : 1);
    check("fill_level", int'(o_level), 4);
    exp_seq = FILTER ? '{1, 3, 0, 2} : '{2, 1, 3, 0};
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fill_pop_dir", int'(o_dir), exp_seq[i]);
    end
    check("fill_empty", int'(o_level), 0);

    // Reversal handling relative to the reference direction.
    reset_dut();
    press(2);
    check("rev_left_level", int'(o_level), FILTER ? 0 : 1);
    press(0); press(1);
    check("rev_updown_level", int'(o_level), FILTER ? 1 : 3);

    // Bounce, then pause behaviour.
    reset_dut();
    press(0);
    tick();
    check("bounce_setup_dir", int'(o_dir), 0);
    repeat (5) begin
      raw[3] = 1'b1; wait_n(10);
      raw[3] = 1'b0; wait_n(2);
    end
    wait_n(25);
    check("bounce_level", int'(o_level), 0);
    press(4);
    check("pause_on", int'(o_paused), 1);
    press(2);
    check("pause_ignore_press", int'(o_level), 0);
    tick();
    check("pause_ignore_tick", int'(o_dir), 0);
    press(4);
    check("pause_off", int'(o_paused), 0);

    // Full queue with simultaneous pop and push.
    reset_dut();
    press(0); press(2); press(1); press(3);
    check("full_setup_level", int'(o_level), 4);
    drop_cnt = 0;
    raw[0] = 1'b1;
    wait_n(18);
    i_tick = 1'b1;
    wait_n(1);
    i_tick = 1'b0;
    check("full_pushpop_level", int'(o_level), 4);
    check("full_pushpop_dir", int'(o_dir), 0);
    wait_n(10);
    raw[0] = 1'b0;
    wait_n(25);
    check("full_pushpop_drop", drop_cnt, 0);
    exp_seq = '{2, 1, 3, 0};
    for (int i = 0; i < 4; i++) begin
      tick();
      check("full_pop_dir", int'(o_dir), exp_seq[i]);
    end

    // Restart while paused with three entries queued.
    reset_dut();
    press(0); press(2); press(1);
    check("restart_setup_level", int'(o_level), 3);
    press(4);
    check("restart_setup_paused", int'(o_paused), 1);
    rst_cnt = 0;
    raw[5] = 1'b1;
    wait_n(19);
    check("restart_pulse", int'(o_restart), 1);
    check("restart_level", int'(o_level), 0);
    check("restart_dir", int'(o_dir), 3);
    check("restart_paused", int'(o_paused), 0);
    wait_n(1);
    check("restart_pulse_end", int'(o_restart), 0);
    wait_n(5);
    raw[5] = 1'b0;
    wait_n(25);
    check("restart_pulse_count", rst_cnt, 1);

    // Reset mid-debounce with a button held through it.
    reset_dut();
    press(0);
    press(4);
    check("midrst_setup_paused", int'(o_paused), 1);
    raw[1] = 1'b1;
    wait_n(10);
    rst = 1'b1;
    wait_n(1);
    rst = 1'b0;
    check_reset_values("midrst");
    wait_n(30);
    raw[1] = 1'b0;
    wait_n(25);
    check("midrst_held_press", int'(o_level), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
